// File: rtl/unload_ship_if.sv
// Handshake bundle between the top-level sequencer and the ship unload controller.
// The sequencer drives start and the on-board counts. The controller drives strobes and status.
interface unload_ship_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic [CNT_W-1:0] crewSize;
  logic [CNT_W-1:0] passengerSize;
  logic [CNT_W-1:0] cargoSpace;
  logic             busy;
  logic             passengerOut;
  logic             cargoOut;
  logic             crewOut;
  logic             done;
  logic [2:0]       nextState;

  modport master (
    output start, crewSize, passengerSize, cargoSpace,
    input  busy, passengerOut, cargoOut, crewOut, done, nextState
  );

  modport slave (
    input  start, crewSize, passengerSize, cargoSpace,
    output busy, passengerOut, cargoOut, crewOut, done, nextState
  );
endinterface

// File: rtl/unload_ship.sv
// Ship unload controller: drains passengers, then cargo, then crew, one item per clock.
// A wrong crew complement parks the controller in ERR until reset.
module unload_ship #(
  parameter int CNT_W      = 4,
  parameter int FIXED_CREW = 4
) (
  input logic          clk,
  input logic          reset,
  unload_ship_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PASS  = 3'd1,
    ST_CARGO = 3'd2,
    ST_CREW  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CREW_REQ = CNT_W'(FIXED_CREW);

  localparam logic [2:0] NS_REST   = 3'b001;
  localparam logic [2:0] NS_UNLOAD = 3'b100;
  localparam logic [2:0] NS_ERROR  = 3'b111;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] p_cnt_q, p_cnt_d;
  logic [CNT_W-1:0] g_cnt_q, g_cnt_d;
  logic [CNT_W-1:0] c_cnt_q, c_cnt_d;

  logic       busy_s;
  logic       pass_out_s;
  logic       cargo_out_s;
  logic       crew_out_s;
  logic       done_s;
  logic [2:0] next_state_s;

  // Saturating decrement: a counter parked at zero stays there.
  function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
    if (v != CNT_ZERO) begin
      dec_sat = v - CNT_ONE;
    end else begin
      dec_sat = CNT_ZERO;
    end
  endfunction

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      p_cnt_q <= CNT_ZERO;
      g_cnt_q <= CNT_ZERO;
      c_cnt_q <= CNT_ZERO;
    end else begin
      state_q <= state_d;
      p_cnt_q <= p_cnt_d;
      g_cnt_q <= g_cnt_d;
      c_cnt_q <= c_cnt_d;
    end
  end

  // Next-state and counter update logic.
  always_comb begin
    state_d = state_q;
    p_cnt_d = p_cnt_q;
    g_cnt_d = g_cnt_q;
    c_cnt_d = c_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          p_cnt_d = bus.passengerSize;
          g_cnt_d = bus.cargoSpace;
          c_cnt_d = bus.crewSize;
          if (bus.crewSize == CREW_REQ) begin
            state_d = ST_PASS;
          end else begin
            state_d = ST_ERR;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PASS: begin
        if (p_cnt_q != CNT_ZERO) begin
          p_cnt_d = dec_sat(p_cnt_q);
        end else begin
          state_d = ST_CARGO;
        end
      end
      ST_CARGO: begin
        if (g_cnt_q != CNT_ZERO) begin
          g_cnt_d = dec_sat(g_cnt_q);
        end else begin
          state_d = ST_CREW;
        end
      end
      ST_CREW: begin
        if (c_cnt_q != CNT_ZERO) begin
          c_cnt_d = dec_sat(c_cnt_q);
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from state and counters; strobes are mutually exclusive by state.
  always_comb begin
    busy_s       = 1'b0;
    pass_out_s   = 1'b0;
    cargo_out_s  = 1'b0;
    crew_out_s   = 1'b0;
    done_s       = 1'b0;
    next_state_s = NS_UNLOAD;
    case (state_q)
      ST_IDLE: begin
        next_state_s = NS_UNLOAD;
      end
      ST_PASS: begin
        busy_s     = 1'b1;
        pass_out_s = (p_cnt_q != CNT_ZERO);
      end
      ST_CARGO: begin
        busy_s      = 1'b1;
        cargo_out_s = (g_cnt_q != CNT_ZERO);
      end
      ST_CREW: begin
        busy_s     = 1'b1;
        crew_out_s = (c_cnt_q != CNT_ZERO);
      end
      ST_DONE: begin
        done_s       = 1'b1;
        next_state_s = NS_REST;
      end
      ST_ERR: begin
        next_state_s = NS_ERROR;
      end
      default: begin
        next_state_s = NS_UNLOAD;
      end
    endcase
  end

  assign bus.busy         = busy_s;
  assign bus.passengerOut = pass_out_s;
  assign bus.cargoOut     = cargo_out_s;
  assign bus.crewOut      = crew_out_s;
  assign bus.done         = done_s;
  assign bus.nextState    = next_state_s;

endmodule

// File: tb/tb_unload_ship.sv
// Self-checking bench for unload_ship: table vectors, random unloads against a
// phase-duration model, and hand-written reset / error / abort sequences.
module tb_unload_ship;

  localparam int CNT_W      = 4;
  localparam int FIXED_CREW = 4;

  localparam logic [7:0] OUT_IDLE = 8'b0000_0100;
  localparam logic [7:0] OUT_ERR  = 8'b0000_0111;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  unload_ship_if #(.CNT_W(CNT_W)) u_if ();

  unload_ship #(.CNT_W(CNT_W), .FIXED_CREW(FIXED_CREW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int p; int g; int k; int crew; int glitch;
    int exp_p; int exp_g; int exp_c; int exp_done;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [7:0] sample_out();
    return {u_if.busy, u_if.passengerOut, u_if.cargoOut, u_if.crewOut,
            u_if.done, u_if.nextState};
  endfunction

  // Expected outputs in cycle c after a start: each phase lasts count+1 cycles.
  function automatic logic [7:0] model_out(int p, int g, int k, int crew, int c);
    if (crew != FIXED_CREW) return OUT_ERR;
    if (c <= p)             return 8'b1100_0100;
    if (c == p + 1)         return 8'b1000_0100;
    if (c <= p + g + 1)     return 8'b1010_0100;
    if (c == p + g + 2)     return 8'b1000_0100;
    if (c <= p + g + k + 2) return 8'b1001_0100;
    if (c == p + g + k + 3) return 8'b1000_0100;
    if (c == p + g + k + 4) return 8'b0000_1001;
    return OUT_IDLE;
  endfunction

  task automatic check(input string name, input int cyc, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_counts(input int p, input int g, input int k);
    u_if.passengerSize = CNT_W'(p);
    u_if.cargoSpace    = CNT_W'(g);
    u_if.crewSize      = CNT_W'(k);
  endtask

  // Starts an unload at the next edge and compares every following cycle to the model.
  task automatic run_unload(input int p, input int g, input int k, input int crew,
                            input int glitch, input int ncyc,
                            output int tp, output int tg, output int tc, output int dcyc);
    logic [7:0] o;
    tp = 0; tg = 0; tc = 0; dcyc = -1;
    drive_counts(p, g, crew);
    u_if.crewSize = CNT_W'(crew);
    u_if.passengerSize = CNT_W'(p);
    u_if.cargoSpace = CNT_W'(g);
    if (k != crew) begin
      u_if.crewSize = CNT_W'(crew);
    end
    u_if.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) u_if.start = 1'b0;
      if (c == glitch) begin
        u_if.start = 1'b1;
        drive_counts(9, 9, 3);
      end
      if (c == glitch + 1) u_if.start = 1'b0;
      o = sample_out();
      check("cycle_outputs", c, int'(o), int'(model_out(p, g, k, crew, c)));
      if (o[6]) tp++;
      if (o[5]) tg++;
      if (o[4]) tc++;
      if (o[3] && dcyc < 0) dcyc = c;
    end
  endtask

  task automatic reset_seq();
    @(negedge clk);
    reset = 1'b1;
    u_if.start = 1'b1;
    drive_counts(2, 2, FIXED_CREW);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("reset_hold", i, int'(sample_out()), int'(OUT_IDLE));
    end
    reset = 1'b0;
    u_if.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_reset_idle", i, int'(sample_out()), int'(OUT_IDLE));
    end
  endtask

  initial begin
    int tp, tg, tc, dc, p, g;
    checks = 0;
    failures = 0;
    reset = 1'b1;
    u_if.start = 1'b0;
    drive_counts(0, 0, 0);

    vecs[0] = '{2, 1, 4, 4, 0, 2, 1, 4, 11};
    vecs[1] = '{15, 0, 4, 4, 0, 15, 0, 4, 23};
    vecs[2] = '{0, 15, 4, 4, 0, 0, 15, 4, 23};
    vecs[3] = '{0, 0, 4, 4, 0, 0, 0, 4, 8};
    vecs[4] = '{3, 2, 4, 4, 5, 3, 2, 4, 13};
    vecs[5] = '{15, 15, 4, 4, 0, 15, 15, 4, 38};

    repeat (2) @(negedge clk);
    reset_seq();

    for (int i = 0; i < 6; i++) begin
      run_unload(vecs[i].p, vecs[i].g, vecs[i].k, vecs[i].crew, vecs[i].glitch,
                 vecs[i].exp_done + 2, tp, tg, tc, dc);
      check("vec_pass_total", i, tp, vecs[i].exp_p);
      check("vec_cargo_total", i, tg, vecs[i].exp_g);
      check("vec_crew_total", i, tc, vecs[i].exp_c);
      check("vec_done_cycle", i, dc, vecs[i].exp_done);
    end

    for (int i = 0; i < 10; i++) begin
      p = int'($urandom_range(0, 15));
      g = int'($urandom_range(0, 15));
      run_unload(p, g, FIXED_CREW, FIXED_CREW, 0, p + g + FIXED_CREW + 6, tp, tg, tc, dc);
      check("rnd_pass_total", i, tp, p);
      check("rnd_cargo_total", i, tg, g);
      check("rnd_crew_total", i, tc, FIXED_CREW);
      check("rnd_done_cycle", i, dc, p + g + FIXED_CREW + 4);
    end

    // Wrong crew: sticky error, later start ignored, reset recovers.
    run_unload(2, 2, 3, 3, 0, 20, tp, tg, tc, dc);
    check("err_strobes", 0, tp + tg + tc, 0);
    check("err_no_done", 0, dc, -1);
    u_if.start = 1'b1;
    drive_counts(1, 1, FIXED_CREW);
    @(negedge clk);
    u_if.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("err_sticky", i, int'(sample_out()), int'(OUT_ERR));
    end
    reset_seq();

    // Abort mid-unload with reset during the third passenger strobe.
    drive_counts(10, 2, FIXED_CREW);
    u_if.start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      u_if.start = 1'b0;
      check("abort_pre", c, int'(sample_out()), int'(model_out(10, 2, 4, 4, c)));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_idle", 4, int'(sample_out()), int'(OUT_IDLE));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_stay_idle", i, int'(sample_out()), int'(OUT_IDLE));
    end
    run_unload(1, 1, FIXED_CREW, FIXED_CREW, 0, 12, tp, tg, tc, dc);
    check("abort_restart_done", 0, dc, 10);
    check("abort_restart_total", 0, tp + tg + tc, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
